window_addr_gen: RTL and testbench
==================================

Name: window_addr_gen

Overview:
- Sliding-window read-address generator that sits directly upstream of the input-buffer read port and the PE accumulate logic.
- On `start` it latches a row length, filter length and stride, then emits every element address of every full window over the row.
- Output uses a valid/ready stream and carries per-window and per-row end flags.
- Internally it is the controller that sequences an element counter and a stepping window-base counter.

Parameters:
- ADDR_WIDTH, 8, width of addresses and of the length/stride configuration inputs.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request to begin a row; honoured only in IDLE
- row_len  in  ADDR_WIDTH  row length in elements; sampled when start is accepted
- filt_len  in  ADDR_WIDTH  window length in elements; sampled when start is accepted
- stride  in  ADDR_WIDTH  window-base increment; sampled when start is accepted; 0 is treated as 1
- busy  out  1  high in every state except IDLE
- addr_valid  out  1  addr holds a valid read address
- addr_ready  in  1  consumer accepts addr this cycle
- addr  out  ADDR_WIDTH  win_base + elem_idx
- win_last  out  1  qualifies addr: last element of the current window
- row_last  out  1  qualifies addr: last element of the last window
- done  out  1  one-cycle pulse at the end of a row

Behaviour:
- **Reset** (rst high at a clock edge, any state): state=IDLE; win_base=0; elem_idx=0; all latched config=0; busy=0, addr_valid=0, done=0. Reset wins over start in the same cycle and aborts a row in progress with no done pulse.
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - start=1: latch config, clear win_base and elem_idx.
  - If filt_len==0 or filt_len>row_len: go to DONE (no addresses are emitted).
  - Otherwise go to RUN.
- **RUN:**
  - addr_valid=1; addr=win_base+elem_idx, truncated to ADDR_WIDTH.
  - Comparisons are done at ADDR_WIDTH+1 bits so that win_base+stride+filt_len cannot wrap.
  - Handshake = addr_valid & addr_ready. Without a handshake, addr, win_last and row_last hold stable.
  - win_last = (elem_idx == filt_len-1).
  - row_last = win_last & (win_base+stride+filt_len > row_len).
  - On handshake with !win_last: elem_idx += 1.
  - On handshake with win_last & !row_last: elem_idx=0; win_base += stride.
  - On handshake with row_last: go to DONE.
- **DONE:** done=1 for exactly one cycle, addr_valid=0, then go to IDLE.
- **Latency:** first addr_valid appears the cycle after start is accepted. done appears the cycle after the row_last handshake (or the cycle after start for a degenerate row).
- **start while busy:** ignored; config inputs are don't-care outside the start-accept cycle.
- **Address count:** windows = floor((row_len-filt_len)/stride)+1. Total addresses = windows*filt_len.

Decomposition:
- **Shared package** (e.g. addr_gen_pkg): state encoding localparams (IDLE, RUN, DONE) and the ADDR_WIDTH default.
- **Sub-module** window_addr_dp: holds the config registers, elem_idx and win_base counters, the adder and the win_last/row_last comparators.
- **Top:** window_addr_gen keeps the FSM and handshake logic and drives the sub-module's clr/en/step controls.

Test Plan:
- **Basic row:** row_len=8, filt_len=3, stride=2, addr_ready=1 → addr sequence 0,1,2,2,3,4,4,5,6. win_last on the 3rd, 6th and 9th addresses; row_last on the 9th only; done pulses 1 cycle after the 9th handshake; busy falls with done.
- **Back-pressure:** same config with addr_ready toggling 1,0,0,1,... → identical sequence; addr and flags stable during every ready=0 cycle; no address dropped or duplicated.
- **Degenerate rows:** filt_len=5, row_len=4 and separately filt_len=0 → addr_valid never asserted; done pulses the cycle after start.
- **Stride 0, exact fit, full range:**
  - row_len=4, filt_len=2, stride=0 → behaves as stride 1: 0,1,1,2,2,3; row_last on the final 3.
  - row_len=3, filt_len=3 → single window 0,1,2; win_last and row_last both on addr 2.
  - ADDR_WIDTH=8, row_len=255, filt_len=255, stride=200 → single window 0..254; no wrap; row_last on 254.
- **Start while busy:** pulse start mid-row with different config → ignored; the original sequence completes unchanged.
- **Reset mid-row:** assert rst after the 4th handshake → next cycle busy=0, addr_valid=0, no done pulse. A new start then restarts from addr 0.

Source files
------------

// File: rtl/window_addr_gen_pkg.sv
// Shared definitions for the sliding-window address generator.
package window_addr_gen_pkg;

  // Default width of addresses and of the length/stride configuration.
  localparam int unsigned ADDR_WIDTH_DEF = 8;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/window_addr_dp.sv
// Datapath for the window address generator: latched config, element and
// window-base counters, address adder and end-of-window/row comparators.
module window_addr_dp
  import window_addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,       // latch config, zero counters
  input  logic                  inc_i,       // next element in window
  input  logic                  step_i,      // next window
  input  logic [ADDR_WIDTH-1:0] row_len_i,
  input  logic [ADDR_WIDTH-1:0] filt_len_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  win_last_o,
  output logic                  row_last_o
);

  // One extra bit so base+stride+filt_len never wraps in the compare.
  localparam int unsigned CW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] row_len_q,  row_len_d;
  logic [ADDR_WIDTH-1:0] filt_len_q, filt_len_d;
  logic [ADDR_WIDTH-1:0] stride_q,   stride_d;
  logic [ADDR_WIDTH-1:0] elem_idx_q, elem_idx_d;
  logic [ADDR_WIDTH-1:0] win_base_q, win_base_d;

  logic [CW-1:0] filt_m1_w;
  logic [CW-1:0] next_end_w;

  // Next-state for config and counters; clr has priority over step/inc.
  always_comb begin
    row_len_d  = row_len_q;
    filt_len_d = filt_len_q;
    stride_d   = stride_q;
    elem_idx_d = elem_idx_q;
    win_base_d = win_base_q;
    if (clr_i) begin
      row_len_d  = row_len_i;
      filt_len_d = filt_len_i;
      // A zero stride would never advance; run it as stride 1.
      stride_d   = (stride_i == '0) ? ADDR_WIDTH'(1) : stride_i;
      elem_idx_d = '0;
      win_base_d = '0;
    end else if (step_i) begin
      elem_idx_d = '0;
      win_base_d = win_base_q + stride_q;
    end else if (inc_i) begin
      elem_idx_d = elem_idx_q + ADDR_WIDTH'(1);
    end
  end

  // Config and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_len_q  <= '0;
      filt_len_q <= '0;
      stride_q   <= '0;
      elem_idx_q <= '0;
      win_base_q <= '0;
    end else begin
      row_len_q  <= row_len_d;
      filt_len_q <= filt_len_d;
      stride_q   <= stride_d;
      elem_idx_q <= elem_idx_d;
      win_base_q <= win_base_d;
    end
  end

  assign filt_m1_w  = {1'b0, filt_len_q} - CW'(1);
  assign next_end_w = {1'b0, win_base_q} + {1'b0, stride_q} + {1'b0, filt_len_q};

  assign addr_o     = win_base_q + elem_idx_q;
  assign win_last_o = ({1'b0, elem_idx_q} == filt_m1_w);
  // Last window when the following window would run past the row.
  assign row_last_o = win_last_o && (next_end_w > {1'b0, row_len_q});

endmodule

// File: rtl/window_addr_gen.sv
// Sliding-window read-address generator: FSM and valid/ready handshake
// sequencing the window datapath.
module window_addr_gen
  import window_addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] row_len,
  input  logic [ADDR_WIDTH-1:0] filt_len,
  input  logic [ADDR_WIDTH-1:0] stride,
  output logic                  busy,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  win_last,
  output logic                  row_last,
  output logic                  done
);

  state_e state_q;
  logic   busy_q, valid_q, done_q;

  logic accept_w, degen_w, hs_w;
  logic inc_w, step_w;

  assign accept_w = (state_q == ST_IDLE) && start;
  // Empty window or window longer than the row: nothing to emit.
  assign degen_w  = (filt_len == '0) || (filt_len > row_len);
  assign hs_w     = valid_q && addr_ready;
  assign inc_w    = hs_w && !win_last;
  assign step_w   = hs_w && win_last && !row_last;

  window_addr_dp #(.ADDR_WIDTH(ADDR_WIDTH)) u_dp (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (accept_w),
    .inc_i      (inc_w),
    .step_i     (step_w),
    .row_len_i  (row_len),
    .filt_len_i (filt_len),
    .stride_i   (stride),
    .addr_o     (addr),
    .win_last_o (win_last),
    .row_last_o (row_last)
  );

  // Controller FSM with registered busy/valid/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (degen_w) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              valid_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (hs_w && row_last) begin
            state_q <= ST_DONE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign addr_valid = valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_window_addr_gen.sv
// Self-checking bench for window_addr_gen: a queue-based row model checked
// every cycle, plus literal address sequences for the directed rows.
module tb_window_addr_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] row_len = '0, filt_len = '0, stride = '0;
  logic       addr_ready = 1'b0;
  logic       busy, addr_valid, win_last, row_last, done;
  logic [7:0] addr;

  window_addr_gen #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .row_len(row_len),
    .filt_len(filt_len), .stride(stride), .busy(busy),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr),
    .win_last(win_last), .row_last(row_last), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct { int a; bit wl; bit rl; } ent_t;
  ent_t exp_q[$];
  bit   m_busy = 0, m_valid = 0, m_done = 0;
  int   log_q[$];

  int q_basic[$]  = '{0, 1, 2, 2, 3, 4, 4, 5, 6};
  int q_str0[$]   = '{0, 1, 1, 2, 2, 3};
  int q_exact[$]  = '{0, 1, 2};
  int q_empty[$];

  // Enumerate every window from the row rules directly.
  task automatic build_row(input int r, input int f, input int s);
    int st;
    exp_q.delete();
    if (f == 0 || f > r) return;
    st = (s == 0) ? 1 : s;
    for (int b = 0; b + f <= r; b += st)
      for (int e = 0; e < f; e++) begin
        ent_t x;
        x.a  = (b + e) % 256;
        x.wl = (e == f - 1);
        x.rl = (e == f - 1) && (b + st + f > r);
        exp_q.push_back(x);
      end
  endtask

  // Compare DUT against the model, log handshakes, then advance the model
  // with the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    tests++;
    if ({busy, addr_valid, done} !== {m_busy, m_valid, m_done}) begin
      fails++;
      $display("FAIL ctrl t=%0t busy/valid/done got %b%b%b exp %b%b%b",
               $time, busy, addr_valid, done, m_busy, m_valid, m_done);
    end
    if (m_valid) begin
      tests++;
      if (addr !== 8'(exp_q[0].a) || win_last !== exp_q[0].wl ||
          row_last !== exp_q[0].rl) begin
        fails++;
        $display("FAIL addr t=%0t got a=%0d wl=%b rl=%b exp a=%0d wl=%b rl=%b",
                 $time, addr, win_last, row_last, exp_q[0].a, exp_q[0].wl, exp_q[0].rl);
      end
    end
    if (addr_valid === 1'b1 && addr_ready) log_q.push_back(int'(addr));
    if (rst) begin
      exp_q.delete(); m_busy = 0; m_valid = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (m_valid) begin
      if (addr_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin m_valid = 0; m_done = 1; end
      end
    end else if (!m_busy && start) begin
      build_row(int'(row_len), int'(filt_len), int'(stride));
      m_busy = 1;
      if (exp_q.size() == 0) m_done = 1; else m_valid = 1;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d exp %0d", nm, got, exp);
    end
  endtask

  task automatic chk_seq(input string nm, input int e[$]);
    int bad = -1;
    tests++;
    for (int i = 0; i < e.size() && i < log_q.size(); i++)
      if (bad < 0 && log_q[i] != e[i]) bad = i;
    if (log_q.size() != e.size() || bad >= 0) begin
      fails++;
      $display("FAIL %s got %0d addrs (first diff idx %0d) exp %0d addrs",
               nm, log_q.size(), bad, e.size());
    end
  endtask

  function automatic bit rdy(input int mode, input int c);
    case (mode)
      0: return 1'b1;
      1: return (c % 3) == 0;
      default: return 1'($urandom_range(1, 0));
    endcase
  endfunction

  // Launch one row and step until the model is idle again.
  task automatic run_row(input int r, input int f, input int s,
                         input int mode, input bit poke);
    int c = 0;
    log_q.delete();
    @(posedge clk); #1;
    start = 1; row_len = 8'(r); filt_len = 8'(f); stride = 8'(s);
    addr_ready = rdy(mode, c);
    @(posedge clk); #1;
    start = 0; row_len = 8'($urandom); filt_len = 8'($urandom); stride = 8'($urandom);
    while (m_busy && c < 3000) begin
      c++;
      addr_ready = rdy(mode, c);
      start = poke && (c == 3 || c == 4);
      @(posedge clk); #1;
    end
    start = 0;
    if (c >= 3000) chk("row_timeout", c, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int c;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(addr_valid), 0);
    chk("reset_done", int'(done), 0);
    rst = 0;

    run_row(8, 3, 2, 0, 0);   chk_seq("basic", q_basic);
    run_row(8, 3, 2, 1, 0);   chk_seq("backpressure", q_basic);
    run_row(8, 3, 2, 2, 0);   chk_seq("rand_ready", q_basic);
    run_row(4, 5, 1, 0, 0);   chk_seq("degen_long", q_empty);
    run_row(4, 0, 1, 0, 0);   chk_seq("degen_zero", q_empty);
    run_row(4, 2, 0, 0, 0);   chk_seq("stride0", q_str0);
    run_row(3, 3, 1, 1, 0);   chk_seq("exact_fit", q_exact);
    run_row(255, 255, 200, 0, 0);
    chk("full_count", log_q.size(), 255);
    chk("full_last", (log_q.size() > 0) ? log_q[log_q.size()-1] : -1, 254);
    run_row(8, 3, 2, 0, 1);   chk_seq("start_busy", q_basic);

    // Abort a row after its 4th accepted address.
    log_q.delete();
    @(posedge clk); #1;
    start = 1; row_len = 8; filt_len = 3; stride = 2; addr_ready = 1;
    @(posedge clk); #1;
    start = 0;
    c = 0;
    while (log_q.size() < 4 && c < 100) begin @(posedge clk); #1; c++; end
    chk("abort_reach", int'(c < 100), 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(addr_valid), 0);
    chk("abort_done", int'(done), 0);
    @(posedge clk); #1;
    chk("abort_no_done", int'(done), 0);
    run_row(8, 3, 2, 0, 0);   chk_seq("restart", q_basic);

    // Random rows; the per-cycle model carries the checking.
    for (int i = 0; i < 40; i++)
      run_row($urandom_range(20, 0), $urandom_range(8, 0),
              $urandom_range(4, 0), $urandom_range(2, 0), 1'($urandom_range(1, 0)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
